// File: rtl/scarv_rom_bus_adapter.sv
// Core req/gnt/recv/ack front-end for a single-port ROM; optional range check via `SCARV_ROM_ADAPTER_RANGE_CHECK_EN.
// Latency: 2 cycles from request acceptance to mem_recv; one request per cycle sustained with prompt acks.
// Backpressure: credit count (FIFO occupancy + in-flight) caps outstanding responses at 2; mem_gnt drops when full.
module scarv_rom_bus_adapter #(
    parameter int          DEPTH     = 1024,
    parameter int          WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     g_clk,
    input  logic                     g_reset,
    input  logic                     mem_req,
    output logic                     mem_gnt,
    input  logic                     mem_wen,
    input  logic [WIDTH/8-1:0]       mem_strb,
    input  logic [WIDTH-1:0]         mem_wdata,
    input  logic [31:0]              mem_addr,
    output logic                     mem_recv,
    input  logic                     mem_ack,
    output logic [WIDTH-1:0]         mem_rdata,
    output logic                     mem_error,
    output logic                     rom_cen,
    output logic [$clog2(DEPTH)-1:0] rom_addr,
    input  logic [WIDTH-1:0]         rom_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int LB = $clog2(WIDTH/8);

    logic [31:0]      off;
    logic             in_range;
    logic             good_rd;
    logic             accept;
    logic             pop;
    logic             push;
    logic [1:0]       cnt;

    logic             inflight;
    logic             tag_err;
    logic [1:0]       occ;
    logic [WIDTH-1:0] head_dat;
    logic             head_err;
    logic [WIDTH-1:0] tail_dat;
    logic             tail_err;
    logic [WIDTH-1:0] push_dat;

    // Strobes and write data are irrelevant to a ROM; fold them away explicitly.
    logic unused_ok;
    assign unused_ok = ^{mem_strb, mem_wdata, off};

    // Address decode: byte offset from the ROM base, word index and range test.
    always_comb begin
        off      = mem_addr - BASE_ADDR;
        rom_addr = off[LB +: AW];
`ifdef SCARV_ROM_ADAPTER_RANGE_CHECK_EN
        in_range = ((off >> (LB + AW)) == 32'd0);
`else
        in_range = 1'b1;
`endif
    end

    // Credit-based grant: a slot frees up in the same cycle the head is popped.
    always_comb begin
        mem_recv = (occ != 2'd0);
        pop      = mem_recv && mem_ack;
        cnt      = occ + {1'b0, inflight};
        mem_gnt  = (cnt < 2'd2) || ((cnt == 2'd2) && pop);
        accept   = mem_req && mem_gnt;
        good_rd  = !mem_wen && in_range;
        rom_cen  = accept && good_rd && !g_reset;
        push     = inflight;
        push_dat = tag_err ? '0 : rom_rdata;
    end

    // Track the request whose ROM data (or error) arrives next cycle.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            inflight <= 1'b0;
            tag_err  <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept) begin
                tag_err <= !good_rd;
            end
        end
    end

    // Two-entry in-order response FIFO with a registered head.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            occ      <= 2'd0;
            head_dat <= '0;
            head_err <= 1'b0;
            tail_dat <= '0;
            tail_err <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_dat <= push_dat;
                        head_err <= tag_err;
                    end else begin
                        tail_dat <= push_dat;
                        tail_err <= tag_err;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd2) begin
                        head_dat <= tail_dat;
                        head_err <= tail_err;
                    end
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd2) begin
                        head_dat <= tail_dat;
                        head_err <= tail_err;
                        tail_dat <= push_dat;
                        tail_err <= tag_err;
                    end else begin
                        head_dat <= push_dat;
                        head_err <= tag_err;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_rdata = head_dat;
    assign mem_error = head_err;

    // The credit rule must never let a push land on a full FIFO without a pop.
    assert property (@(posedge g_clk) disable iff (g_reset)
        !(push && (occ == 2'd2) && !pop));

endmodule

// File: tb/tb_scarv_rom_bus_adapter.sv
module tb_scarv_rom_bus_adapter;

`ifdef SCARV_ROM_ADAPTER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_wen;
    logic [3:0]  mem_strb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic        mem_recv;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        rom_cen;
    logic [9:0]  rom_addr;
    logic [31:0] rom_rdata;

    int checks = 0;
    int errors = 0;

    always #5 g_clk = ~g_clk;

    scarv_rom_bus_adapter #(.DEPTH(1024), .WIDTH(32), .BASE_ADDR(32'h0)) dut (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_wen   (mem_wen),
        .mem_strb  (mem_strb),
        .mem_wdata (mem_wdata),
        .mem_addr  (mem_addr),
        .mem_recv  (mem_recv),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_error (mem_error),
        .rom_cen   (rom_cen),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata)
    );

    function automatic logic [31:0] rom_word(input logic [9:0] a);
        if (a == 10'd5) return 32'hDEAD_BEEF;
        return 32'h1000_0000 | {22'd0, a};
    endfunction

    // One-cycle-latency ROM model
    always @(posedge g_clk) begin
        if (rom_cen) rom_rdata <= rom_word(rom_addr);
    end

    typedef struct {
        logic        req;
        logic        wen;
        logic [31:0] addr;
        logic        ack;
        logic        gnt;
        logic        cen;
        logic [9:0]  raddr;
        logic        recv;
        logic        chk_dat;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic req, input logic wen, input logic [31:0] addr,
                                input logic ack, input logic gnt, input logic cen,
                                input logic [9:0] raddr, input logic recv, input logic chk_dat,
                                input logic [31:0] rdata, input logic err);
        vec_t v;
        v.req = req; v.wen = wen; v.addr = addr; v.ack = ack;
        v.gnt = gnt; v.cen = cen; v.raddr = raddr; v.recv = recv;
        v.chk_dat = chk_dat; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic k);
        @(posedge g_clk);
        #1;
        mem_req  = r;
        mem_wen  = w;
        mem_addr = a;
        mem_ack  = k;
    endtask

    initial begin
        g_reset   = 1'b1;
        mem_req   = 1'b0;
        mem_wen   = 1'b0;
        mem_strb  = 4'hF;
        mem_wdata = 32'h5555_AAAA;
        mem_addr  = 32'h0;
        mem_ack   = 1'b1;

        //           req wen addr          ack gnt cen  raddr recv chk rdata              err
        vecs[0]  = mk(0, 0, 32'h0,        1,  1,  0,   0,    0,   1,  32'h0,             0);
        vecs[1]  = mk(1, 0, 32'h14,       1,  1,  1,   5,    0,   0,  32'h0,             0);
        vecs[2]  = mk(0, 0, 32'h0,        1,  1,  0,   0,    0,   0,  32'h0,             0);
        vecs[3]  = mk(0, 0, 32'h0,        1,  1,  0,   0,    1,   1,  32'hDEAD_BEEF,     0);
        vecs[4]  = mk(1, 0, 32'h0,        1,  1,  1,   0,    0,   0,  32'h0,             0);
        vecs[5]  = mk(1, 0, 32'h4,        1,  1,  1,   1,    0,   0,  32'h0,             0);
        vecs[6]  = mk(1, 0, 32'h8,        1,  1,  1,   2,    1,   1,  32'h1000_0000,     0);
        vecs[7]  = mk(0, 0, 32'h0,        1,  1,  0,   0,    1,   1,  32'h1000_0001,     0);
        vecs[8]  = mk(0, 0, 32'h0,        1,  1,  0,   0,    1,   1,  32'h1000_0002,     0);
        vecs[9]  = mk(0, 0, 32'h0,        1,  1,  0,   0,    0,   0,  32'h0,             0);
        vecs[10] = mk(1, 1, 32'h8,        1,  1,  0,   2,    0,   0,  32'h0,             0);
        vecs[11] = mk(0, 0, 32'h0,        1,  1,  0,   0,    0,   0,  32'h0,             0);
        vecs[12] = mk(0, 0, 32'h0,        1,  1,  0,   0,    1,   1,  32'h0,             1);
        vecs[13] = mk(1, 0, 32'h1000,     1,  1,  !RC, 0,    0,   0,  32'h0,             0);
        vecs[14] = mk(0, 0, 32'h0,        1,  1,  0,   0,    0,   0,  32'h0,             0);
        vecs[15] = mk(0, 0, 32'h0,        1,  1,  0,   0,    1,   1,  RC ? 32'h0 : 32'h1000_0000, RC);
        vecs[16] = mk(1, 0, 32'h17,       1,  1,  1,   5,    0,   0,  32'h0,             0);
        vecs[17] = mk(0, 0, 32'h0,        1,  1,  0,   0,    0,   0,  32'h0,             0);
        vecs[18] = mk(0, 0, 32'h0,        1,  1,  0,   0,    1,   1,  32'hDEAD_BEEF,     0);

        repeat (2) @(posedge g_clk);
        #1 g_reset = 1'b0;

        // Table-driven single-cycle vectors
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].req, vecs[i].wen, vecs[i].addr, vecs[i].ack);
            @(negedge g_clk);
            chk($sformatf("v%0d_gnt", i),   {31'd0, mem_gnt},  {31'd0, vecs[i].gnt});
            chk($sformatf("v%0d_cen", i),   {31'd0, rom_cen},  {31'd0, vecs[i].cen});
            chk($sformatf("v%0d_raddr", i), {22'd0, rom_addr}, {22'd0, vecs[i].raddr});
            chk($sformatf("v%0d_recv", i),  {31'd0, mem_recv}, {31'd0, vecs[i].recv});
            if (vecs[i].chk_dat) begin
                chk($sformatf("v%0d_rdata", i), mem_rdata,          vecs[i].rdata);
                chk($sformatf("v%0d_err", i),   {31'd0, mem_error}, {31'd0, vecs[i].err});
            end
        end

        // Stall: ack low, requests held -> two accepts then gnt drops, head held
        drive(1, 0, 32'h4, 0);
        @(negedge g_clk);
        chk("stall_a0_gnt", {31'd0, mem_gnt}, 32'd1);
        drive(1, 0, 32'h8, 0);
        @(negedge g_clk);
        chk("stall_a1_gnt", {31'd0, mem_gnt}, 32'd1);
        drive(1, 0, 32'hC, 0);
        @(negedge g_clk);
        chk("stall_a2_gnt",  {31'd0, mem_gnt},  32'd0);
        chk("stall_a2_recv", {31'd0, mem_recv}, 32'd1);
        chk("stall_a2_data", mem_rdata,         32'h1000_0001);
        for (int c = 0; c < 5; c++) begin
            drive(1, 0, 32'hC, 0);
            @(negedge g_clk);
            chk($sformatf("stall_h%0d_gnt", c),  {31'd0, mem_gnt},   32'd0);
            chk($sformatf("stall_h%0d_cen", c),  {31'd0, rom_cen},   32'd0);
            chk($sformatf("stall_h%0d_recv", c), {31'd0, mem_recv},  32'd1);
            chk($sformatf("stall_h%0d_data", c), mem_rdata,          32'h1000_0001);
            chk($sformatf("stall_h%0d_err", c),  {31'd0, mem_error}, 32'd0);
        end
        drive(1, 0, 32'hC, 1);
        @(negedge g_clk);
        chk("drain0_gnt",   {31'd0, mem_gnt},  32'd1);
        chk("drain0_cen",   {31'd0, rom_cen},  32'd1);
        chk("drain0_raddr", {22'd0, rom_addr}, 32'd3);
        chk("drain0_recv",  {31'd0, mem_recv}, 32'd1);
        chk("drain0_data",  mem_rdata,         32'h1000_0001);
        drive(0, 0, 32'h0, 1);
        @(negedge g_clk);
        chk("drain1_recv", {31'd0, mem_recv}, 32'd1);
        chk("drain1_data", mem_rdata,         32'h1000_0002);
        drive(0, 0, 32'h0, 1);
        @(negedge g_clk);
        chk("drain2_recv", {31'd0, mem_recv}, 32'd1);
        chk("drain2_data", mem_rdata,         32'h1000_0003);
        drive(0, 0, 32'h0, 1);
        @(negedge g_clk);
        chk("drain3_recv", {31'd0, mem_recv}, 32'd0);

        // Reset with a response in flight: it must never be delivered
        drive(1, 0, 32'h14, 1);
        @(negedge g_clk);
        chk("rst_r0_cen", {31'd0, rom_cen}, 32'd1);
        drive(1, 0, 32'h14, 1);
        g_reset = 1'b1;
        @(negedge g_clk);
        chk("rst_r1_cen", {31'd0, rom_cen}, 32'd0);
        drive(0, 0, 32'h0, 1);
        g_reset = 1'b0;
        @(negedge g_clk);
        chk("rst_r2_gnt",   {31'd0, mem_gnt},   32'd1);
        chk("rst_r2_data",  mem_rdata,          32'h0);
        chk("rst_r2_err",   {31'd0, mem_error}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("rst_r%0d_recv", c + 2), {31'd0, mem_recv}, 32'd0);
            drive(0, 0, 32'h0, 1);
            @(negedge g_clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
